// File: rtl/sub64_pipe_pkg.sv
// Shared types and widths for the pipelined subtractor.
package sub64_pipe_pkg;

    localparam int LEN_DATA = 64;

    typedef struct packed {
        logic borrow;
        logic neg;
        logic zero;
        logic ovf;
    } flags_t;

endpackage

// File: rtl/sub64_pipe_prefix.sv
// One combinational Kogge-Stone level of the subtractor carry tree.
module sub_prefix_stage #(
    parameter int WIDTH = 64,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] gn,
    output logic [WIDTH-1:0] pn
);

    assign gn = g | (p & (g << DIST));
    assign pn = p & (p << DIST);

endmodule

// File: rtl/sub64_pipe.sv
// Fully pipelined a - b with valid tags and occupancy count.
// Define SUB64_FLAGS_EN to build borrow/neg/zero/ovf result flags.
module sub64_pipe
    import sub64_pipe_pkg::*;
#(
    parameter int WIDTH = LEN_DATA
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             out_vld,
    output logic             borrow,
    output logic             neg,
    output logic             zero,
    output logic             ovf,
    output logic             busy
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int LAT    = LEVELS + 2;
    localparam int CW     = $clog2(LAT + 1);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [LAT-1:0]   vld;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] g_q  [LEVELS];
    logic [WIDTH-1:0] p_q  [LEVELS];
    logic [WIDTH-1:0] p0_q [LEVELS];
    logic [WIDTH-1:0] g_n  [LEVELS];
    logic [WIDTH-1:0] p_n  [LEVELS];
    logic [WIDTH-1:0] p_in;
    logic [WIDTH-1:0] g_in;
    logic [WIDTH-1:0] diff_n;
    logic [WIDTH-1:0] diff_q;
    logic [WIDTH:0]   unused_pg;
    flags_t           flags_n;
    flags_t           flags_q;

    // Carry-in of 1 is folded into bit 0 generate: g0 |= p0.
    assign p_in = a_q ^ ~b_q;
    assign g_in = (a_q & ~b_q)
                | {{(WIDTH-1){1'b0}}, p_in[0]};

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        sub_prefix_stage #(
            .WIDTH(WIDTH),
            .DIST (1 << l)
        ) u_lvl (
            .g (g_q[l]),
            .p (p_q[l]),
            .gn(g_n[l]),
            .pn(p_n[l])
        );
    end

    assign diff_n = p0_q[LEVELS-1]
                  ^ {g_n[LEVELS-1][WIDTH-2:0], 1'b1};

`ifdef SUB64_FLAGS_EN
    logic [LEVELS-1:0] am_q;
    logic [LEVELS-1:0] bm_q;

    always_comb begin
        flags_n        = '0;
        flags_n.borrow = ~g_n[LEVELS-1][WIDTH-1];
        flags_n.neg    = diff_n[WIDTH-1];
        flags_n.zero   = (diff_n == '0);
        flags_n.ovf    = (am_q[LEVELS-1] != bm_q[LEVELS-1])
                       & (diff_n[WIDTH-1] != am_q[LEVELS-1]);
    end

    assign unused_pg = {p_n[LEVELS-1], 1'b0};

    always_ff @(posedge clk) begin
        if (!rst) begin
            am_q    <= '0;
            bm_q    <= '0;
            flags_q <= '0;
        end else if (en) begin
            am_q    <= {am_q[LEVELS-2:0], a_q[WIDTH-1]};
            bm_q    <= {bm_q[LEVELS-2:0], b_q[WIDTH-1]};
            flags_q <= flags_n;
        end
    end
`else
    assign flags_n   = '0;
    assign flags_q   = '0;
    assign unused_pg = {p_n[LEVELS-1], g_n[LEVELS-1][WIDTH-1]};
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_q    <= '0;
            b_q    <= '0;
            vld    <= '0;
            cnt    <= '0;
            diff_q <= '0;
            for (int l = 0; l < LEVELS; l++) begin
                g_q[l]  <= '0;
                p_q[l]  <= '0;
                p0_q[l] <= '0;
            end
        end else if (en) begin
            a_q     <= a;
            b_q     <= b;
            vld     <= {vld[LAT-2:0], in_vld};
            cnt     <= cnt + CW'(in_vld) - CW'(vld[LAT-1]);
            g_q[0]  <= g_in;
            p_q[0]  <= p_in;
            p0_q[0] <= p_in;
            for (int l = 1; l < LEVELS; l++) begin
                g_q[l]  <= g_n[l-1];
                p_q[l]  <= p_n[l-1];
                p0_q[l] <= p0_q[l-1];
            end
            diff_q <= diff_n;
        end
    end

    assign diff    = diff_q;
    assign out_vld = vld[LAT-1];
    assign borrow  = flags_q.borrow;
    assign neg     = flags_q.neg;
    assign zero    = flags_q.zero;
    assign ovf     = flags_q.ovf;
    assign busy    = (cnt != '0);

endmodule
